// File: rtl/mac_acc_pkg.sv
// Shared constants, entry type and saturation limits for the MAC result accumulator.
package mac_acc_pkg;

  localparam int unsigned MAC_LATENCY_CFG = 3;
  localparam int unsigned ACC_W_CFG       = 32;
  localparam int unsigned MAC_RES_W       = 32;
  localparam int unsigned ACC_W_MAX       = 64;

  typedef struct packed {
    logic                 ovf;
    logic [ACC_W_CFG-1:0] data;
  } acc_entry_t;

  // Limits returned in ACC_W_MAX bits; callers keep the low w bits.
  function automatic logic [ACC_W_MAX-1:0] sat_max(input int unsigned w);
    return (ACC_W_MAX'(1) << (w - 1)) - ACC_W_MAX'(1);
  endfunction

  function automatic logic [ACC_W_MAX-1:0] sat_min(input int unsigned w);
    return ACC_W_MAX'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/mac_result_accumulator_if.sv
// Issue/result/output bundle between operand issuer, MAC and the accumulator.
interface mac_result_accumulator_if
  import mac_acc_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_CFG
);
  logic                 issue_valid;
  logic                 issue_last;
  logic                 issue_ready;
  logic [MAC_RES_W-1:0] mac_result;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_W-1:0]     out_data;
  logic                 out_ovf;

  modport master (
    output issue_valid, issue_last, mac_result, out_ready,
    input  issue_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  issue_valid, issue_last, mac_result, out_ready,
    output issue_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/acc_out_fifo.sv
// Synchronous first-word-fall-through FIFO holding finished group sums.
module acc_out_fifo
  import mac_acc_pkg::*;
#(
  parameter  int unsigned DEPTH   = 2,
  parameter  int unsigned ENTRY_W = $bits(acc_entry_t),
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] din_i,
  input  logic               pop_i,
  output logic [ENTRY_W-1:0] dout_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               empty_o
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               full;
  logic               do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(do_pop);
    end
  end

  // Credit flow control upstream must keep this from ever firing.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full));

endmodule

// File: rtl/mac_result_accumulator.sv
// Re-times MAC tags, accumulates dot-product groups and queues sums under credit flow control.
module mac_result_accumulator
  import mac_acc_pkg::*;
#(
  parameter int unsigned MAC_LATENCY = MAC_LATENCY_CFG,
  parameter int unsigned ACC_W       = ACC_W_CFG,
  parameter int unsigned OUT_DEPTH   = 2,
  parameter bit          SATURATE    = 1'b1
) (
  input logic                     clock,
  input logic                     reset,
  mac_result_accumulator_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int unsigned EXT_W = ACC_W + 1 - MAC_RES_W;
  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W));
  localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ACC_W));

  logic [MAC_LATENCY-1:0] tag_v_q, tag_v_d, tag_l_q, tag_l_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic                   first_q, first_d;
  logic                   ovf_q, ovf_d;
  logic                   push_q, push_d;
  logic [ACC_W:0]         push_entry_q, push_entry_d;
  logic [CNT_W-1:0]       credit_q, credit_d;
  logic                   ready_q, ready_d;

  logic                   acc_beat, issued_last, pop;
  logic [ACC_W-1:0]       base, sum;
  logic [ACC_W:0]         wide;
  logic                   rng_ovf, grp_ovf;
  logic [ACC_W:0]         head;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_empty;

  assign acc_beat    = bus.issue_valid & ready_q;
  assign issued_last = acc_beat & bus.issue_last;
  assign pop         = ~fifo_empty & bus.out_ready;

  // Tag pipe, accumulator and credit next-state.
  always_comb begin
    tag_v_d      = MAC_LATENCY'({tag_v_q, acc_beat});
    tag_l_d      = MAC_LATENCY'({tag_l_q, issued_last});
    acc_d        = acc_q;
    first_d      = first_q;
    ovf_d        = ovf_q;
    push_d       = 1'b0;
    push_entry_d = push_entry_q;

    base    = first_q ? '0 : acc_q;
    wide    = {base[ACC_W-1], base}
            + {{EXT_W{bus.mac_result[MAC_RES_W-1]}}, bus.mac_result};
    rng_ovf = wide[ACC_W] ^ wide[ACC_W-1];
    sum     = wide[ACC_W-1:0];
    if (SATURATE && rng_ovf) sum = wide[ACC_W] ? SAT_MIN : SAT_MAX;
    grp_ovf = ovf_q | rng_ovf;

    // mac_result is only meaningful when the aligned tag says a beat was accepted.
    if (tag_v_q[MAC_LATENCY-1]) begin
      if (tag_l_q[MAC_LATENCY-1]) begin
        push_d       = 1'b1;
        push_entry_d = {grp_ovf, sum};
        acc_d        = '0;
        ovf_d        = 1'b0;
        first_d      = 1'b1;
      end else begin
        acc_d   = sum;
        ovf_d   = grp_ovf;
        first_d = 1'b0;
      end
    end

    // Freed credits reach issue_ready one cycle late; consumed ones block immediately.
    credit_d = credit_q + CNT_W'(pop) - CNT_W'(issued_last);
    ready_d  = (credit_q - CNT_W'(issued_last)) != '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tag_v_q      <= '0;
      tag_l_q      <= '0;
      acc_q        <= '0;
      first_q      <= 1'b1;
      ovf_q        <= 1'b0;
      push_q       <= 1'b0;
      push_entry_q <= '0;
      credit_q     <= CNT_W'(OUT_DEPTH);
      ready_q      <= 1'b0;
    end else begin
      tag_v_q      <= tag_v_d;
      tag_l_q      <= tag_l_d;
      acc_q        <= acc_d;
      first_q      <= first_d;
      ovf_q        <= ovf_d;
      push_q       <= push_d;
      push_entry_q <= push_entry_d;
      credit_q     <= credit_d;
      ready_q      <= ready_d;
    end
  end

  acc_out_fifo #(
    .DEPTH   (OUT_DEPTH),
    .ENTRY_W (ACC_W + 1)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (push_q),
    .din_i   (push_entry_q),
    .pop_i   (pop),
    .dout_o  (head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign bus.issue_ready = ready_q;
  assign bus.out_valid   = ~fifo_empty;
  assign bus.out_data    = head[ACC_W-1:0];
  assign bus.out_ovf     = head[ACC_W];

  a_credit_bound: assert property (@(posedge clock) disable iff (reset)
    (32'(credit_q) + 32'(fifo_count)) <= 32'(OUT_DEPTH));

endmodule

// File: tb/tb_mac_result_accumulator.sv
// Directed bench: one saturating and one wrapping accumulator fed identical traffic.
module tb_mac_result_accumulator;
  localparam int unsigned MAC_LAT = 3;
  localparam int unsigned DEPTH   = 2;
  localparam logic [31:0] GARBAGE = 32'hDEAD_BEEF;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid, issue_last, out_ready;
  logic [31:0] beat_val;
  logic [31:0] mac_pipe [MAC_LAT];
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  mac_result_accumulator_if #(.ACC_W(32)) bs ();
  mac_result_accumulator_if #(.ACC_W(32)) bw ();

  // Fixed-latency MAC model: whatever sits on the operand bus emerges MAC_LAT cycles later.
  always @(posedge clock) begin
    mac_pipe[0] <= beat_val;
    for (int i = 1; i < int'(MAC_LAT); i++) mac_pipe[i] <= mac_pipe[i-1];
  end

  assign bs.issue_valid = issue_valid;
  assign bs.issue_last  = issue_last;
  assign bs.out_ready   = out_ready;
  assign bs.mac_result  = mac_pipe[MAC_LAT-1];
  assign bw.issue_valid = issue_valid;
  assign bw.issue_last  = issue_last;
  assign bw.out_ready   = out_ready;
  assign bw.mac_result  = mac_pipe[MAC_LAT-1];

  mac_result_accumulator #(
    .MAC_LATENCY (MAC_LAT), .ACC_W (32), .OUT_DEPTH (DEPTH), .SATURATE (1'b1)
  ) u_sat (
    .clock (clock), .reset (reset), .bus (bs)
  );

  mac_result_accumulator #(
    .MAC_LATENCY (MAC_LAT), .ACC_W (32), .OUT_DEPTH (DEPTH), .SATURATE (1'b0)
  ) u_wrap (
    .clock (clock), .reset (reset), .bus (bw)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    issue_valid = 1'b0;
    issue_last  = 1'b0;
    beat_val    = GARBAGE;
    repeat (n) @(negedge clock);
  endtask

  // Present one beat and hold it until accepted; returns at the negedge after acceptance.
  task automatic issue(input logic [31:0] v, input logic last);
    int n = 0;
    issue_valid = 1'b1;
    issue_last  = last;
    beat_val    = v;
    while (!bs.issue_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("issue_accept_timeout", 32'(n < 50), 32'd1);
    @(negedge clock);
    issue_valid = 1'b0;
    issue_last  = 1'b0;
    beat_val    = GARBAGE;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bs.out_valid && n < 30) begin
      @(negedge clock);
      n++;
    end
    check("out_valid_timeout", 32'(n < 30), 32'd1);
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          acc_cnt;
    logic [31:0] popped [$];

    reset       = 1'b1;
    issue_valid = 1'b0;
    issue_last  = 1'b0;
    out_ready   = 1'b0;
    beat_val    = GARBAGE;
    repeat (4) @(negedge clock);

    check("rst_issue_ready", 32'(bs.issue_ready), 32'd0);
    check("rst_out_valid",   32'(bs.out_valid),   32'd0);
    check("rst_out_data",    bs.out_data,         32'd0);
    check("rst_out_ovf",     32'(bs.out_ovf),     32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_ready",  32'(bs.issue_ready), 32'd1);

    // Group 10,-3,7,1 -> 15, visible MAC_LAT+1 cycles after the last beat.
    issue(32'd10, 1'b0);
    issue(32'hFFFF_FFFD, 1'b0);
    issue(32'd7, 1'b0);
    issue(32'd1, 1'b1);
    repeat (MAC_LAT) @(negedge clock);
    check("grp1_valid_early", 32'(bs.out_valid), 32'd0);
    @(negedge clock);
    check("grp1_valid",     32'(bs.out_valid), 32'd1);
    check("grp1_data_sat",  bs.out_data,       32'd15);
    check("grp1_ovf",       32'(bs.out_ovf),   32'd0);
    check("grp1_data_wrap", bw.out_data,       32'd15);
    pop_one();
    check("grp1_popped", 32'(bs.out_valid), 32'd0);

    // Positive overflow: clamp vs wrap, sticky ovf on both.
    issue(32'h7FFF_FFF0, 1'b0);
    issue(32'h0000_0020, 1'b1);
    wait_valid();
    check("ovf_data_sat",  bs.out_data,     32'h7FFF_FFFF);
    check("ovf_flag_sat",  32'(bs.out_ovf), 32'd1);
    check("ovf_data_wrap", bw.out_data,     32'h8000_0010);
    check("ovf_flag_wrap", 32'(bw.out_ovf), 32'd1);
    pop_one();

    // Back-to-back one-beat groups with the sink stalled; one pop frees exactly one slot.
    acc_cnt = 0;
    popped.delete();
    for (int cyc = 0; cyc < 24; cyc++) begin
      issue_valid = 1'b1;
      issue_last  = 1'b1;
      beat_val    = 32'd100 + 32'(acc_cnt);
      out_ready   = (cyc == 12);
      if (cyc == 11) begin
        check("stall_accepted", 32'(acc_cnt),        32'(DEPTH));
        check("stall_ready",    32'(bs.issue_ready), 32'd0);
      end
      if (out_ready && bs.out_valid) popped.push_back(bs.out_data);
      if (bs.issue_ready) acc_cnt++;
      @(negedge clock);
    end
    check("pulse_accepted", 32'(acc_cnt),        32'(DEPTH + 1));
    check("pulse_ready",    32'(bs.issue_ready), 32'd0);
    idle(0);
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (bs.out_valid) popped.push_back(bs.out_data);
      @(negedge clock);
    end
    out_ready = 1'b0;
    check("order_count", 32'(popped.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < popped.size()) check($sformatf("order_%0d", i), popped[i], 32'd100 + 32'(i));

    // Garbage on mac_result between beats of one group must not leak in.
    idle(5);
    issue(32'd2, 1'b0);
    idle(3);
    issue(32'd3, 1'b1);
    wait_valid();
    check("garbage_sum_sat",  bs.out_data, 32'd5);
    check("garbage_sum_wrap", bw.out_data, 32'd5);
    pop_one();

    // Reset with a partial sum of 50 and two beats still in the MAC.
    issue(32'd30, 1'b0);
    issue(32'd20, 1'b0);
    idle(4);
    issue(32'd7, 1'b0);
    issue(32'd8, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("midrst_ready", 32'(bs.issue_ready), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check($sformatf("midrst_valid_%0d", i), 32'(bs.out_valid), 32'd0);
    end
    issue(32'd5, 1'b0);
    issue(32'd5, 1'b1);
    wait_valid();
    check("midrst_sum", bs.out_data,     32'd10);
    check("midrst_ovf", 32'(bs.out_ovf), 32'd0);
    pop_one();

    // Push and pop on the same edge with one entry already queued.
    issue(32'd40, 1'b1);
    wait_valid();
    issue(32'd41, 1'b1);
    repeat (MAC_LAT) @(negedge clock);
    check("pp_head_before",  bs.out_data,         32'd40);
    check("pp_ready_before", 32'(bs.issue_ready), 32'd0);
    pop_one();
    check("pp_valid_after",  32'(bs.out_valid),   32'd1);
    check("pp_head_after",   bs.out_data,         32'd41);
    check("pp_ready_after",  32'(bs.issue_ready), 32'd0);
    repeat (2) @(negedge clock);
    check("pp_ready_freed",  32'(bs.issue_ready), 32'd1);
    pop_one();
    check("pp_drained",      32'(bs.out_valid),   32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
